// File: rtl/leak_mon_pkg.sv
// Shared types and helpers for the capacitance-bus leakage monitor:
// FSM encoding, saturation limits and the 8-bit popcount.
package leak_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MONITOR = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_e;

    localparam logic [11:0] SAT12 = 12'hFFF;
    localparam logic [15:0] SAT16 = 16'hFFFF;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/leak_fifo.sv
// Sample capture FIFO, DEPTH x 8 (DEPTH a power of two, >= 2), with
// registered empty/full flags and registered read data / valid pulse.
module leak_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_i,
    input  logic       push_i,
    input  logic [7:0] data_i,
    input  logic       pop_i,
    output logic [7:0] rd_data_o,
    output logic       rd_valid_o,
    output logic       empty_o,
    output logic       full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    rd_data_q;
    logic          rd_valid_q, empty_q, full_q;
    logic          push_ok, pop_ok;

    // Both flags describe occupancy before this cycle, so a full FIFO drops pushes
    assign push_ok = push_i && !full_q && !clr_i;
    assign pop_ok  = pop_i && !empty_q && !clr_i;

    always_comb begin
        cnt_d = cnt_q;
        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            rd_data_q  <= 8'd0;
            rd_valid_q <= 1'b0;
        end else if (clr_i) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop_ok) begin
                rptr_q    <= rptr_q + 1'b1;
                rd_data_q <= mem_q[rptr_q];
            end
            rd_valid_q <= pop_ok;
            cnt_q      <= cnt_d;
            empty_q    <= (cnt_d == '0);
            full_q     <= (cnt_d == CW'(DEPTH));
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign empty_o    = empty_q;
    assign full_o     = full_q;

endmodule

// File: rtl/leak_monitor.sv
// Toggle-activity monitor for the AES-T1000 capacitance leakage bus.
// Define LEAK_MON_ACT_CNT_EN to build the saturating alarmed-window counter.
module leak_monitor
    import leak_mon_pkg::*;
#(
    parameter int WINDOW = 256,
    parameter int THRESH = 16,
    parameter int DEPTH  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [7:0]  cap_in,
    input  logic        clr,
    output logic        alarm,
    output logic [11:0] win_toggles,
    input  logic        rd_en,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        empty,
    output logic        full,
    output logic [15:0] act_count
);

    localparam int WCNT_W = $clog2(WINDOW);

    function automatic logic [11:0] sat_add12(input logic [11:0] a, input logic [3:0] b);
        logic [12:0] s;
        s = {1'b0, a} + {9'd0, b};
        return s[12] ? SAT12 : s[11:0];
    endfunction

    logic [7:0]        cur_q, prev_q;
    state_e            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [11:0]       acc_q, acc_d;
    logic [11:0]       wt_q, wt_d;
    logic              alarm_q, alarm_d;
    logic [11:0]       sum;
    logic              win_last, over_thr, push;

    // prev tracks cur continuously, so a window opened after IDLE sees no stale delta
    always_ff @(posedge clk) begin
        cur_q  <= cap_in;
        prev_q <= cur_q;
    end

    assign sum      = sat_add12(acc_q, popcount8(cur_q ^ prev_q));
    assign win_last = (wcnt_q == WCNT_W'(WINDOW - 1));
    assign over_thr = ({20'd0, sum} >= 32'(THRESH));

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        acc_d   = acc_q;
        wt_d    = wt_q;
        alarm_d = alarm_q;
        push    = 1'b0;
        if (clr) begin
            state_d = IDLE;
            wcnt_d  = '0;
            acc_d   = '0;
            alarm_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    wcnt_d = '0;
                    acc_d  = '0;
                    if (en) state_d = MONITOR;
                end
                MONITOR: begin
                    if (!en) begin
                        state_d = IDLE;
                        wcnt_d  = '0;
                        acc_d   = '0;
                    end else if (win_last) begin
                        wt_d   = sum;
                        wcnt_d = '0;
                        acc_d  = '0;
                        if (over_thr) begin
                            alarm_d = 1'b1;
                            state_d = CAPTURE;
                        end
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                        acc_d  = sum;
                    end
                end
                CAPTURE: begin
                    if (!en) begin
                        state_d = IDLE;
                    end else if (full) begin
                        state_d = HOLD;
                    end else begin
                        push = 1'b1;
                    end
                end
                HOLD: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            acc_q   <= '0;
            wt_q    <= '0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            acc_q   <= acc_d;
            wt_q    <= wt_d;
            alarm_q <= alarm_d;
        end
    end

    leak_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i      (clk),
        .rst_ni     (rst),
        .clr_i      (clr),
        .push_i     (push),
        .data_i     (cur_q),
        .pop_i      (rd_en),
        .rd_data_o  (rd_data),
        .rd_valid_o (rd_valid),
        .empty_o    (empty),
        .full_o     (full)
    );

`ifdef LEAK_MON_ACT_CNT_EN
    logic [15:0] act_q;
    logic        act_inc;

    assign act_inc = !clr && en && (state_q == MONITOR) && win_last && over_thr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_q <= '0;
        end else if (act_inc && (act_q != SAT16)) begin
            act_q <= act_q + 16'd1;
        end
    end

    assign act_count = act_q;
`else
    assign act_count = 16'd0;
`endif

    assign alarm       = alarm_q;
    assign win_toggles = wt_q;

endmodule

// File: doc/leak_monitor.md
# leak_monitor

On-chip monitor for the 8-bit `capacitance` leakage bus driven by the trojan payload in the AES-T1000 top level. It sits beside the AES core as the receiving end of that bus and measures bit-toggle activity over fixed windows. When activity crosses a threshold it raises a sticky alarm and captures a burst of raw bus samples into a small FIFO for host readout. It gives the team a hardware-side detector for evaluating trojan activation on FPGA.

## Interface
Parameters:
- `WINDOW`, default 256: observation window length in cycles; power of two, ≥ 4.
- `THRESH`, default 16: toggle count per window at or above which the alarm fires.
- `DEPTH`, default 16: capture FIFO depth in samples; power of two.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `en` in 1: monitoring enable. While low, no window is open.
- `cap_in` in 8: leakage bus under observation.
- `clr` in 1: synchronous clear of the alarm and the FIFO; returns the FSM to IDLE.
- `alarm` out 1: sticky detection flag.
- `win_toggles` out 12: toggle total of the last completed window, saturating at 4095.
- `rd_en` in 1: pop request for the FIFO.
- `rd_data` out 8: popped sample.
- `rd_valid` out 1: `rd_data` is valid this cycle.
- `empty` out 1: FIFO empty flag.
- `full` out 1: FIFO full flag.
- `act_count` out 16: count of alarmed windows (feature-dependent, see Configuration).

## Operation
- `cap_in` is registered once into `cur`. The previous value is held in `prev`. The per-cycle toggle count is popcount(`cur` ^ `prev`), range 0–8.
- The accumulator adds this count every cycle. It saturates at 4095 and never wraps.
- FSM states:
  - IDLE: entered at reset, on `clr`, or whenever `en` is low.
  - MONITOR: entered from IDLE when `en` is high. The window counter runs 0..WINDOW-1. On the last cycle of the window:
    - `win_toggles` takes the final sum, including that cycle's count.
    - The accumulator restarts.
    - If the sum ≥ THRESH, `alarm` is set and the FSM goes to CAPTURE. Otherwise it stays in MONITOR.
  - CAPTURE: pushes `cur` into the FIFO every cycle until `full`, then goes to HOLD. A pop in the same cycle as a push is allowed; occupancy stays constant.
  - HOLD: no windows and no pushes. The FSM waits for `clr`.
- `alarm` clears only on `clr` or reset.
- `en` falling in any state other than HOLD aborts to IDLE. The partial window is discarded and `win_toggles` is unchanged.
- `clr` has priority over every other event in the same cycle. It empties the FIFO and clears `alarm`. It does not clear `win_toggles` or `act_count`.
- `rd_en` with `empty` high is ignored: `rd_valid` stays 0 and the pointers do not move.
- Pushes are blocked when `full`. Samples arriving while full are dropped silently.

## Timing
- Reset values: `alarm` 0, `win_toggles` 0, `rd_data` 0, `rd_valid` 0, `empty` 1, `full` 0, `act_count` 0. FSM starts in IDLE.
- `cap_in` to toggle contribution: 1 cycle. The first MONITOR cycle uses `prev` = the value held since IDLE, so there is no spurious toggle burst.
- Alarm latency: `alarm` rises the cycle after the last window cycle. The first push occurs that same cycle.
- Read latency: `rd_en` at cycle N gives `rd_data`/`rd_valid` at N+1. `rd_valid` is a single-cycle pulse.
- `empty`/`full` are registered and reflect occupancy after the current cycle's push/pop.

## Configuration
- `LEAK_MON_ACT_CNT_EN` defined:
  - `act_count` increments on every window that sets or re-qualifies the alarm.
  - It saturates at 65535 and resets only on `rst`.
- Undefined: `act_count` is tied to 0 and no counter is synthesised.

## Structure
- Shared package `leak_mon_pkg` holds:
  - the FSM state encoding (IDLE, MONITOR, CAPTURE, HOLD, 2-bit);
  - the saturation constants (12-bit, 16-bit);
  - the popcount function.
- One sub-module, `leak_fifo`: a synchronous FIFO, DEPTH×8, with registered flags and registered read data.

## Test plan
- Reset mid-CAPTURE (after 5 pushes), `rst` low asynchronously -> all outputs at reset values immediately; `empty`=1 after release.
- `en`=1, `cap_in` constant 8'h00 for 3 windows -> `win_toggles`=0 each window, `alarm`=0, FIFO `empty`=1.
- `cap_in` alternating 8'h01/8'h00 every cycle, WINDOW=256, THRESH=16 -> `win_toggles`=256 (first window 255 if the first cycle has no change), `alarm` rises 1 cycle after window end, `full`=1 after 16 pushes, FSM in HOLD.
- Exactly THRESH-1 toggles in a window, then exactly THRESH -> no alarm on the first window, alarm on the second; `act_count`=1 with `LEAK_MON_ACT_CNT_EN`, 0 without.
- After capture, 17 `rd_en` pulses -> 16 `rd_valid` pulses with samples in push order, 17th ignored, `empty`=1; then `clr` -> `alarm`=0, FSM in IDLE.
- `clr` and window-end-over-threshold in the same cycle -> `alarm` stays 0, no push, FSM in IDLE.
